mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 24 ++
 rtl/mem_port_arbiter_watchdog.sv | 46 ++++
 rtl/mem_port_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared CPU package: machine word width, arbiter state encoding, default watchdog limit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_port_arbiter_pkg;

    localparam int unsigned XLEN = 32;

    // Busy cycles without a memory ack before the watchdog flag sets.
    localparam logic [7:0] ARB_TIMEOUT_DEFAULT = 8'd255;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'b00,
        ARB_IF_BUSY  = 2'b01,
        ARB_MEM_BUSY = 2'b10
    } arb_state_e;

    // One access as presented to the shared single-port memory.
    typedef struct packed {
        logic            we;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } ram_cmd_t;

endpackage

// File: rtl/mem_port_arbiter_watchdog.sv
// Purpose: busy-cycle watchdog; 8-bit counter, sticky flag once the count reaches limit_i.
// Latency: flag_o rises on the edge where the count reaches limit_i.
// Backpressure: none; observe-only.
// Ports: clk_i/rst_i (sync, active-high), clr_i zeroes the count, cnt_en_i counts one cycle,
//        limit_i sets the trip point, flag_o stays high until reset.
module arb_watchdog (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clr_i,
    input  logic       cnt_en_i,
    input  logic [7:0] limit_i,
    output logic       flag_o
);

    logic [7:0] cnt_q, cnt_d;
    logic       flag_q, flag_d;
    logic       inc;

    always_comb begin
        cnt_d  = cnt_q;
        flag_d = flag_q;
        // Saturate so a long stall never wraps the count back under the limit.
        inc    = cnt_en_i && !clr_i && (cnt_q != 8'hFF);
        if (clr_i) begin
            cnt_d = 8'd0;
        end else if (inc) begin
            cnt_d = cnt_q + 8'd1;
        end
        if (inc && (cnt_d == limit_i)) begin
            flag_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= 8'd0;
            flag_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            flag_q <= flag_d;
        end
    end

    assign flag_o = flag_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one single-port memory between fetch (IF) and data (MEM); MEM wins ties.
// Latency: ram_req_o one cycle after a request is seen; back-to-back grants with no bubble.
// Backpressure: stall_o holds the pipeline while any held request is unserved.
// Ports: if_* fetch side, mem_* load/store side, ram_* registered memory port,
//        stall_o pipeline freeze, timeout_o sticky watchdog flag.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter logic [7:0] TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            if_req_i,
    input  logic [XLEN-1:0] if_addr_i,
    output logic [XLEN-1:0] if_rdata_o,
    output logic            if_ack_o,
    input  logic            mem_req_i,
    input  logic            mem_we_i,
    input  logic [XLEN-1:0] mem_addr_i,
    input  logic [XLEN-1:0] mem_wdata_i,
    output logic [XLEN-1:0] mem_rdata_o,
    output logic            mem_ack_o,
    output logic            ram_req_o,
    output logic            ram_we_o,
    output logic [XLEN-1:0] ram_addr_o,
    output logic [XLEN-1:0] ram_wdata_o,
    input  logic [XLEN-1:0] ram_rdata_i,
    input  logic            ram_ack_i,
    output logic            stall_o,
    output logic            timeout_o
);

    arb_state_e state_q, state_d;
    logic       req_q, req_d;
    ram_cmd_t   cmd_q, cmd_d;
    logic       if_done_q, if_done_d;
    logic       mem_done_q, mem_done_d;

    logic       if_elig, mem_elig;
    logic       if_ack, mem_ack, stall;
    logic       wd_clr, wd_en;
    ram_cmd_t   if_cmd, mem_cmd;

    // Done flags stop a held request from being served twice in one pipeline step.
    assign if_elig  = if_req_i  && !if_done_q;
    assign mem_elig = mem_req_i && !mem_done_q;

    // Acks only count in the matching busy state, so stray acks in IDLE vanish.
    assign if_ack   = ram_ack_i && (state_q == ARB_IF_BUSY);
    assign mem_ack  = ram_ack_i && (state_q == ARB_MEM_BUSY);
    assign stall    = (if_elig && !if_ack) || (mem_elig && !mem_ack);

    assign if_cmd   = '{we: 1'b0, addr: if_addr_i, wdata: '0};
    assign mem_cmd  = '{we: mem_we_i, addr: mem_addr_i, wdata: mem_wdata_i};

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        cmd_d      = cmd_q;
        if_done_d  = if_done_q;
        mem_done_d = mem_done_q;

        case (state_q)
            ARB_IDLE: begin
                if (mem_elig) begin
                    state_d = ARB_MEM_BUSY;
                    req_d   = 1'b1;
                    cmd_d   = mem_cmd;
                end else if (if_elig) begin
                    state_d = ARB_IF_BUSY;
                    req_d   = 1'b1;
                    cmd_d   = if_cmd;
                end
            end
            ARB_IF_BUSY: begin
                if (ram_ack_i) begin
                    if (mem_elig) begin
                        state_d = ARB_MEM_BUSY;
                        cmd_d   = mem_cmd;
                    end else begin
                        state_d = ARB_IDLE;
                        req_d   = 1'b0;
                    end
                end
            end
            ARB_MEM_BUSY: begin
                if (ram_ack_i) begin
                    if (if_elig) begin
                        state_d = ARB_IF_BUSY;
                        cmd_d   = if_cmd;
                    end else begin
                        state_d = ARB_IDLE;
                        req_d   = 1'b0;
                    end
                end
            end
            default: begin
                state_d = ARB_IDLE;
                req_d   = 1'b0;
            end
        endcase

        // The pipeline advances whenever nothing stalls it; a new step starts clean.
        if (!stall) begin
            if_done_d  = 1'b0;
            mem_done_d = 1'b0;
        end else begin
            if (if_ack)  if_done_d  = 1'b1;
            if (mem_ack) mem_done_d = 1'b1;
        end
    end

    // Entering a busy state (from IDLE, or directly across on an ack) restarts the count.
    assign wd_clr = (state_d != ARB_IDLE) && ((state_q == ARB_IDLE) || ram_ack_i);
    assign wd_en  = (state_q != ARB_IDLE) && !ram_ack_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ARB_IDLE;
            req_q      <= 1'b0;
            cmd_q      <= '0;
            if_done_q  <= 1'b0;
            mem_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            cmd_q      <= cmd_d;
            if_done_q  <= if_done_d;
            mem_done_q <= mem_done_d;
        end
    end

    arb_watchdog u_watchdog (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (wd_clr),
        .cnt_en_i (wd_en),
        .limit_i  (TIMEOUT),
        .flag_o   (timeout_o)
    );

    assign if_ack_o    = if_ack;
    assign mem_ack_o   = mem_ack;
    assign stall_o     = stall;
    assign if_rdata_o  = ram_rdata_i;
    assign mem_rdata_o = ram_rdata_i;
    assign ram_req_o   = req_q;
    assign ram_we_o    = cmd_q.we;
    assign ram_addr_o  = cmd_q.addr;
    assign ram_wdata_o = cmd_q.wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose: directed cycle tables plus hand sequences for watchdog and mid-transaction reset.
// Latency: inputs driven on the falling edge, outputs sampled 1 ns later.
// Backpressure: ram_ack_i timing is scripted per row.
module tb_mem_port_arbiter;

    localparam logic [31:0] IFA = 32'h0000_0010;
    localparam logic [31:0] MA  = 32'h0000_0020;
    localparam logic [31:0] WD  = 32'hDEAD_BEEF;
    localparam logic [31:0] RD  = 32'h8C01_0004;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_rdata_o;
    logic        if_ack_o;
    logic        mem_req_i;
    logic        mem_we_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic [31:0] mem_rdata_o;
    logic        mem_ack_o;
    logic        ram_req_o;
    logic        ram_we_o;
    logic [31:0] ram_addr_o;
    logic [31:0] ram_wdata_o;
    logic [31:0] ram_rdata_i;
    logic        ram_ack_i;
    logic        stall_o;
    logic        timeout_o;

    always #5 clk = ~clk;

    mem_port_arbiter #(.TIMEOUT(8'd4)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_rdata_o  (if_rdata_o),
        .if_ack_o    (if_ack_o),
        .mem_req_i   (mem_req_i),
        .mem_we_i    (mem_we_i),
        .mem_addr_i  (mem_addr_i),
        .mem_wdata_i (mem_wdata_i),
        .mem_rdata_o (mem_rdata_o),
        .mem_ack_o   (mem_ack_o),
        .ram_req_o   (ram_req_o),
        .ram_we_o    (ram_we_o),
        .ram_addr_o  (ram_addr_o),
        .ram_wdata_o (ram_wdata_o),
        .ram_rdata_i (ram_rdata_i),
        .ram_ack_i   (ram_ack_i),
        .stall_o     (stall_o),
        .timeout_o   (timeout_o)
    );

    typedef struct {
        logic        if_req;
        logic        mem_req;
        logic        mem_we;
        logic        ack;
        logic        e_req;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic        e_ifack;
        logic        e_memack;
        logic        e_stall;
    } vec_t;

    vec_t vq[$];
    int   n_pass = 0;
    int   n_chk  = 0;

    function automatic vec_t v(input logic ifr, input logic mr, input logic we, input logic ack,
                               input logic e_req, input logic e_we, input logic [31:0] e_addr,
                               input logic [31:0] e_wd, input logic e_ifa, input logic e_ma,
                               input logic e_st);
        vec_t r;
        r.if_req = ifr;  r.mem_req = mr;  r.mem_we = we;  r.ack = ack;
        r.e_req = e_req; r.e_we = e_we;   r.e_addr = e_addr; r.e_wdata = e_wd;
        r.e_ifack = e_ifa; r.e_memack = e_ma; r.e_stall = e_st;
        return r;
    endfunction

    task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    initial begin
        logic [133:0] act, exp;

        // Reset state
        vq.push_back(v(0,0,0,0, 0,0,32'h0,32'h0, 0,0,0));
        // IF only: request, two waiting cycles, ack, release
        vq.push_back(v(1,0,0,0, 0,0,32'h0,32'h0, 0,0,1));
        vq.push_back(v(1,0,0,0, 1,0,IFA,32'h0,   0,0,1));
        vq.push_back(v(1,0,0,0, 1,0,IFA,32'h0,   0,0,1));
        vq.push_back(v(1,0,0,1, 1,0,IFA,32'h0,   1,0,0));
        vq.push_back(v(0,0,0,0, 0,0,IFA,32'h0,   0,0,0));
        // IF and MEM store together: MEM first, zero-bubble switch to IF,
        // held mem_req not re-served, three waits each side stay under the watchdog
        vq.push_back(v(1,1,1,0, 0,0,IFA,32'h0,   0,0,1));
        vq.push_back(v(1,1,1,0, 1,1,MA,WD,       0,0,1));
        vq.push_back(v(1,1,1,0, 1,1,MA,WD,       0,0,1));
        vq.push_back(v(1,1,1,0, 1,1,MA,WD,       0,0,1));
        vq.push_back(v(1,1,1,1, 1,1,MA,WD,       0,1,1));
        vq.push_back(v(1,1,1,0, 1,0,IFA,32'h0,   0,0,1));
        vq.push_back(v(1,1,1,0, 1,0,IFA,32'h0,   0,0,1));
        vq.push_back(v(1,1,1,0, 1,0,IFA,32'h0,   0,0,1));
        vq.push_back(v(1,1,1,1, 1,0,IFA,32'h0,   1,0,0));
        // Next pipeline step: mem_done cleared, MEM served again, 1-cycle ack latency
        vq.push_back(v(0,1,1,0, 0,0,IFA,32'h0,   0,0,1));
        vq.push_back(v(0,1,1,1, 1,1,MA,WD,       0,1,0));
        vq.push_back(v(0,0,0,0, 0,1,MA,WD,       0,0,0));
        // Stray acks in IDLE, with and without a pending request
        vq.push_back(v(0,0,0,1, 0,1,MA,WD,       0,0,0));
        vq.push_back(v(0,0,0,0, 0,1,MA,WD,       0,0,0));
        vq.push_back(v(1,0,0,1, 0,1,MA,WD,       0,0,1));
        vq.push_back(v(1,0,0,1, 1,0,IFA,32'h0,   1,0,0));
        vq.push_back(v(0,0,0,0, 0,0,IFA,32'h0,   0,0,0));
        // IF busy, MEM load arrives late: IF ack hands over directly to MEM
        vq.push_back(v(1,0,0,0, 0,0,IFA,32'h0,   0,0,1));
        vq.push_back(v(1,1,0,0, 1,0,IFA,32'h0,   0,0,1));
        vq.push_back(v(1,1,0,1, 1,0,IFA,32'h0,   1,0,1));
        vq.push_back(v(1,1,0,1, 1,0,MA,WD,       0,1,0));
        vq.push_back(v(0,0,0,0, 0,0,MA,WD,       0,0,0));

        rst_i = 1'b1; if_req_i = 1'b0; mem_req_i = 1'b0; mem_we_i = 1'b0;
        ram_ack_i = 1'b0; ram_rdata_i = RD;
        if_addr_i = IFA; mem_addr_i = MA; mem_wdata_i = WD;
        repeat (2) @(posedge clk);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            rst_i       = 1'b0;
            if_req_i    = vq[i].if_req;
            mem_req_i   = vq[i].mem_req;
            mem_we_i    = vq[i].mem_we;
            ram_ack_i   = vq[i].ack;
            ram_rdata_i = RD + 32'(i);
            #1;
            act = {ram_req_o, ram_we_o, ram_addr_o, ram_wdata_o, if_ack_o, mem_ack_o,
                   stall_o, timeout_o, if_rdata_o, mem_rdata_o};
            exp = {vq[i].e_req, vq[i].e_we, vq[i].e_addr, vq[i].e_wdata, vq[i].e_ifack,
                   vq[i].e_memack, vq[i].e_stall, 1'b0, RD + 32'(i), RD + 32'(i)};
            check($sformatf("row%0d", i), act, exp);
        end

        // Watchdog: MEM load with no ack trips after 4 busy cycles, stays set until reset
        @(negedge clk); rst_i = 1'b1; if_req_i = 1'b0; mem_req_i = 1'b0; ram_ack_i = 1'b0;
        @(negedge clk); rst_i = 1'b0; mem_req_i = 1'b1; mem_we_i = 1'b0;
        #1 check("to_reset", {ram_req_o, ram_addr_o, timeout_o}, '0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            #1 check($sformatf("to_wait%0d", k), {ram_req_o, timeout_o}, 2'b10);
        end
        @(negedge clk);
        #1 check("to_set", {ram_req_o, timeout_o}, 2'b11);
        ram_ack_i = 1'b1;
        #1 check("to_ack", {mem_ack_o, timeout_o}, 2'b11);
        @(negedge clk); ram_ack_i = 1'b0; mem_req_i = 1'b0;
        #1 check("to_sticky", {ram_req_o, timeout_o}, 2'b01);
        repeat (3) @(negedge clk);
        #1 check("to_sticky2", timeout_o, 1'b1);
        @(negedge clk); rst_i = 1'b1;
        @(negedge clk); rst_i = 1'b0;
        #1 check("to_clear", timeout_o, 1'b0);

        // Reset in MEM_BUSY, ack arrives the cycle after: dropped
        @(negedge clk); mem_req_i = 1'b1; mem_we_i = 1'b1;
        @(negedge clk);
        #1 check("rb_busy", {ram_req_o, ram_we_o, ram_addr_o}, {2'b11, MA});
        rst_i = 1'b1;
        @(negedge clk); rst_i = 1'b0; ram_ack_i = 1'b1; mem_req_i = 1'b0; mem_we_i = 1'b0;
        #1 check("rb_ack", {mem_ack_o, if_ack_o, ram_req_o, stall_o}, 4'b0000);
        check("rb_regs", {ram_we_o, ram_addr_o, ram_wdata_o}, '0);
        @(negedge clk); ram_ack_i = 1'b0;
        #1 check("rb_idle", {ram_req_o, mem_ack_o, stall_o}, 3'b000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
